// File: rtl/mdio_responder.sv
// Clause-22 MDIO responder (PHY side). MDC/MDIO are oversampled in the clk_mac
// domain; frames addressed to PHY_ADDR are turned into single-cycle register
// read/write strobes, and read data is shifted back out on the MDIO pad.
module mdio_responder #(
    parameter logic [4:0]  PHY_ADDR      = 5'd1,
    parameter int unsigned PREAMBLE_BITS = 32,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic        clk_mac,
    input  logic        rst,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    output logic [4:0]  reg_addr,
    output logic        reg_re,
    input  logic [15:0] reg_rdata,
    output logic        reg_we,
    output logic [15:0] reg_wdata,
    output logic        frame_err
);

    typedef enum logic [2:0] {
        StPre, StSt, StOp, StPhyad, StRegad, StTa, StRdata, StWdata
    } state_e;

    localparam logic [5:0] PreFull = 6'(PREAMBLE_BITS);

    logic [SYNC_STAGES-1:0] mdc_sync_q;
    logic [SYNC_STAGES-1:0] mdio_sync_q;
    logic                   mdc_prev_q;
    logic                   mdc_rise;
    logic                   bit_in;

    state_e      state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [5:0]  pre_cnt_q, pre_cnt_d;
    logic        op_hi_q, op_hi_d;
    logic        is_read_q, is_read_d;
    logic        ta_ok_q, ta_ok_d;
    logic [15:0] shift_q, shift_d;
    logic        mdio_o_q, mdio_o_d;
    logic        mdio_oe_q, mdio_oe_d;
    logic [4:0]  reg_addr_q, reg_addr_d;
    logic [15:0] reg_wdata_q, reg_wdata_d;
    logic        reg_re_q, reg_re_d;
    logic        reg_we_q, reg_we_d;
    logic        frame_err_q, frame_err_d;
    logic        rd_cap_q;

    // MDC and MDIO travel through identical synchronizer chains so that the
    // data bit seen on the detected rising edge is the one the master set up.
    always_ff @(posedge clk_mac or posedge rst) begin
        if (rst) begin
            mdc_sync_q  <= '0;
            mdio_sync_q <= '0;
            mdc_prev_q  <= 1'b0;
        end else begin
            mdc_sync_q  <= {mdc_sync_q[SYNC_STAGES-2:0], mdc};
            mdio_sync_q <= {mdio_sync_q[SYNC_STAGES-2:0], mdio_i};
            mdc_prev_q  <= mdc_sync_q[SYNC_STAGES-1];
        end
    end

    assign mdc_rise = mdc_sync_q[SYNC_STAGES-1] & ~mdc_prev_q;
    assign bit_in   = mdio_sync_q[SYNC_STAGES-1];

    // Frame state and all registered outputs.
    always_ff @(posedge clk_mac or posedge rst) begin
        if (rst) begin
            state_q     <= StPre;
            bit_cnt_q   <= '0;
            pre_cnt_q   <= '0;
            op_hi_q     <= 1'b0;
            is_read_q   <= 1'b0;
            ta_ok_q     <= 1'b0;
            shift_q     <= '0;
            mdio_o_q    <= 1'b0;
            mdio_oe_q   <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_re_q    <= 1'b0;
            reg_we_q    <= 1'b0;
            frame_err_q <= 1'b0;
            rd_cap_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            pre_cnt_q   <= pre_cnt_d;
            op_hi_q     <= op_hi_d;
            is_read_q   <= is_read_d;
            ta_ok_q     <= ta_ok_d;
            shift_q     <= shift_d;
            mdio_o_q    <= mdio_o_d;
            mdio_oe_q   <= mdio_oe_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_re_q    <= reg_re_d;
            reg_we_q    <= reg_we_d;
            frame_err_q <= frame_err_d;
            rd_cap_q    <= reg_re_q;
        end
    end

    // Next-state decode; everything except the read-data capture advances only
    // on a synchronized MDC rising edge.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        pre_cnt_d   = pre_cnt_q;
        op_hi_d     = op_hi_q;
        is_read_d   = is_read_q;
        ta_ok_d     = ta_ok_q;
        shift_d     = shift_q;
        mdio_o_d    = mdio_o_q;
        mdio_oe_d   = mdio_oe_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_re_d    = 1'b0;
        reg_we_d    = 1'b0;
        frame_err_d = 1'b0;

        // Register file answers one cycle after reg_re; edges are far apart
        // enough that this never collides with an MDC edge update.
        if (rd_cap_q) begin
            shift_d = reg_rdata;
        end

        if (mdc_rise) begin
            unique case (state_q)
                StPre: begin
                    if (bit_in) begin
                        if (pre_cnt_q != PreFull) pre_cnt_d = pre_cnt_q + 6'd1;
                    end else if (pre_cnt_q == PreFull) begin
                        state_d   = StSt;
                        pre_cnt_d = '0;
                    end else begin
                        pre_cnt_d = '0;
                    end
                end
                StSt: begin
                    bit_cnt_d = '0;
                    if (bit_in) begin
                        state_d = StOp;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StPre;
                    end
                end
                StOp: begin
                    if (bit_cnt_q == 5'd0) begin
                        op_hi_d   = bit_in;
                        bit_cnt_d = 5'd1;
                    end else if (op_hi_q != bit_in) begin
                        is_read_d = op_hi_q;
                        bit_cnt_d = '0;
                        state_d   = StPhyad;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StPre;
                    end
                end
                StPhyad: begin
                    shift_d = {shift_q[14:0], bit_in};
                    if (bit_cnt_q == 5'd4) begin
                        bit_cnt_d = '0;
                        // Other PHYs' frames are dropped without any side effect.
                        state_d = ({shift_q[3:0], bit_in} == PHY_ADDR) ? StRegad : StPre;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                StRegad: begin
                    shift_d = {shift_q[14:0], bit_in};
                    if (bit_cnt_q == 5'd4) begin
                        reg_addr_d = {shift_q[3:0], bit_in};
                        reg_re_d   = is_read_q;
                        bit_cnt_d  = '0;
                        state_d    = StTa;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                StTa: begin
                    if (bit_cnt_q == 5'd0) begin
                        ta_ok_d   = bit_in;
                        bit_cnt_d = 5'd1;
                    end else begin
                        bit_cnt_d = '0;
                        if (is_read_q) begin
                            // Second turnaround bit: take the bus and drive 0.
                            mdio_oe_d = 1'b1;
                            mdio_o_d  = 1'b0;
                            state_d   = StRdata;
                        end else if (ta_ok_q && !bit_in) begin
                            state_d = StWdata;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = StPre;
                        end
                    end
                end
                StRdata: begin
                    if (bit_cnt_q == 5'd16) begin
                        mdio_oe_d = 1'b0;
                        mdio_o_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = StPre;
                    end else begin
                        mdio_o_d  = shift_q[15];
                        shift_d   = {shift_q[14:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                StWdata: begin
                    shift_d = {shift_q[14:0], bit_in};
                    if (bit_cnt_q == 5'd15) begin
                        reg_wdata_d = {shift_q[14:0], bit_in};
                        reg_we_d    = 1'b1;
                        bit_cnt_d   = '0;
                        state_d     = StPre;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                default: state_d = StPre;
            endcase
        end
    end

    assign mdio_o    = mdio_o_q;
    assign mdio_oe   = mdio_oe_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_re    = reg_re_q;
    assign reg_we    = reg_we_q;
    assign frame_err = frame_err_q;

endmodule
